sap_control_sequencer: RTL
==========================

Name: sap_control_sequencer

Overview:
- Microcoded control unit for the 8-bit bus machine. It generates every load and output-enable strobe that drives the accumulator, B register, ALU, RAM/MAR, program counter and output register.
- It sits directly upstream of the accumulator/ALU stage. It commands `a_load`, `b_load`, `alu_out` and `alu_sub`, and consumes the ALU's CF/ZF.
- It steps through a T-state counter, decodes the 4-bit opcode from the instruction register, and latches flags for conditional jumps.

Parameters:
- STEP_W, 3, width of the T-state counter (holds T0..T4).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ena  in  1  run enable; low = stall (state held, all controls 0)
- ir_opcode  in  4  upper nibble of instruction register
- alu_cf  in  1  ALU carry-out, valid while alu_out asserted
- alu_zf  in  1  ALU zero flag, valid while alu_out asserted
- pc_out  out  1  PC drives bus
- pc_inc  out  1  PC increment
- pc_load  out  1  PC loads from bus
- mar_load  out  1  memory address register loads from bus
- ram_out  out  1  RAM drives bus
- ram_load  out  1  RAM writes bus
- ir_load  out  1  instruction register loads from bus
- ir_out  out  1  IR low nibble drives bus
- a_load  out  1  accumulator loads from bus
- a_out  out  1  accumulator drives bus
- b_load  out  1  B register loads from bus
- alu_out  out  1  ALU result drives bus
- alu_sub  out  1  ALU subtract select
- out_load  out  1  output register loads from bus
- flag_c  out  1  latched carry flag
- flag_z  out  1  latched zero flag
- halted  out  1  HLT executed

Behaviour:
- Clock, reset and state:
  - One clock; reset is synchronous and active-high (`rst`). Clock port is named `clk`.
  - Registered state: `step` (T0..T4), `halt_q`, `flag_c`, `flag_z`.
  - All control outputs are combinational decode of (`step`, `ir_opcode`, flags, `halt_q`, `ena`, `rst`).
- Reset (`rst`=1 at edge):
  - `step`=T0, `halt_q`=0, `flag_c`=0, `flag_z`=0.
  - While `rst`=1, every control output is forced 0.
  - Reset mid-instruction aborts it; the next cycle with `ena`=1 starts a fetch at T0.
- Fetch, common to all opcodes:
  - T0: `pc_out`, `mar_load`.
  - T1: `ram_out`, `ir_load`, `pc_inc`.
- Execute:
  - 0x0 NOP: T2 no strobes.
  - 0x1 LDA: T2 `ir_out`, `mar_load`; T3 `ram_out`, `a_load`.
  - 0x2 ADD: T2 `ir_out`, `mar_load`; T3 `ram_out`, `b_load`; T4 `alu_out`, `a_load`, flag update.
  - 0x3 SUB: as ADD, with `alu_sub`=1 during T4 only.
  - 0x4 STA: T2 `ir_out`, `mar_load`; T3 `a_out`, `ram_load`.
  - 0x5 LDI: T2 `ir_out`, `a_load`.
  - 0x6 JMP: T2 `ir_out`, `pc_load`.
  - 0x7 JC: T2 `ir_out`, with `pc_load` only if `flag_c`=1.
  - 0x8 JZ: T2 `ir_out`, with `pc_load` only if `flag_z`=1.
  - 0xE OUT: T2 `a_out`, `out_load`.
  - 0xF HLT: T2 sets `halt_q` at the edge.
  - 0x9-0xD: treated as NOP.
- Step sequencing:
  - After an opcode's last active step, `step` returns to T0; no idle T-states.
  - Instruction lengths: NOP/LDI/JMP/JC/JZ/OUT/undefined 3 cycles; LDA/STA 4; ADD/SUB 5.
  - `step` never exceeds T4.
- Flags:
  - At the T4 edge of ADD/SUB, `flag_c`<=`alu_cf` and `flag_z`<=`alu_zf`.
  - Flags are held at all other times. JC/JZ use flag values registered before T2, never live ALU inputs.
- Halt:
  - Once `halt_q`=1, `step` is held, all controls are 0 and `halted`=1 until `rst`.
  - `ena` has no effect while halted.
- Stall (`ena`=0):
  - `step`, flags and `halt_q` are held; all controls are 0.
  - Resuming re-issues the same step's strobes exactly once.
- Exclusivity: at most one bus driver per cycle (`pc_out`, `ram_out`, `ir_out`, `a_out`, `alu_out`). The bench checks this as an assertion.

Decomposition:
- Shared package `sap_pkg`:
  - opcode constants (OP_NOP..OP_HLT);
  - T-state constants T0..T4;
  - packed control-word struct, field order as the port list;
  - per-opcode instruction-length constants.
- One natural sub-module, `sap_microcode_rom`: purely combinational (opcode, step, `flag_c`, `flag_z`) -> control word plus `last_step` bit.
- The top keeps the step counter, flag and halt registers, and the `ena`/`rst` gating.

Test Plan:
- Reset then fetch: hold `rst`=1 for 2 cycles, release with `ena`=1, `ir_opcode`=0x0.
  - Cycle 0: `pc_out`=`mar_load`=1.
  - Cycle 1: `ram_out`=`ir_load`=`pc_inc`=1.
  - Cycle 2: all 0.
  - Cycle 3: back to T0.
- ADD with carry: opcode 0x2, drive `alu_cf`=1, `alu_zf`=0 at T4.
  - T4: `alu_out`=`a_load`=1, `alu_sub`=0.
  - After the edge: `flag_c`=1, `flag_z`=0; next cycle T0.
- SUB to zero, then JZ: SUB with `alu_zf`=1 at T4, then opcode 0x8.
  - `alu_sub`=1 only at T4.
  - JZ T2: `ir_out`=`pc_load`=1.
  - Repeating with `flag_z`=0 gives `pc_load`=0.
- Stall mid-instruction: LDA, drop `ena` for 3 cycles at T3.
  - Controls 0 during the stall.
  - On resume: `ram_out`=`a_load`=1 for exactly one cycle, then T0.
- HLT then reset: opcode 0xF.
  - After T2: `halted`=1 and all controls 0 for 10 cycles despite `ena`=1.
  - `rst` pulse: `halted`=0, flags 0, fetch restarts at T0.
- Sweep all 16 opcodes across all steps: assert single bus driver per cycle and the cycle counts 3/4/5 as specified.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP control sequencer: opcodes, T-states,
// the control word layout and instruction lengths.
package sap_pkg;

    localparam int SAP_STEP_W = 3;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [SAP_STEP_W-1:0] T0 = 3'd0;
    localparam logic [SAP_STEP_W-1:0] T1 = 3'd1;
    localparam logic [SAP_STEP_W-1:0] T2 = 3'd2;
    localparam logic [SAP_STEP_W-1:0] T3 = 3'd3;
    localparam logic [SAP_STEP_W-1:0] T4 = 3'd4;

    localparam logic [SAP_STEP_W-1:0] LEN_SHORT = 3'd3;
    localparam logic [SAP_STEP_W-1:0] LEN_MEM   = 3'd4;
    localparam logic [SAP_STEP_W-1:0] LEN_ALU   = 3'd5;

    typedef struct packed {
        logic pc_out;
        logic pc_inc;
        logic pc_load;
        logic mar_load;
        logic ram_out;
        logic ram_load;
        logic ir_load;
        logic ir_out;
        logic a_load;
        logic a_out;
        logic b_load;
        logic alu_out;
        logic alu_sub;
        logic out_load;
    } ctrl_word_t;

    function automatic logic [SAP_STEP_W-1:0] instr_len(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA: return LEN_MEM;
            OP_ADD, OP_SUB: return LEN_ALU;
            default:        return LEN_SHORT;
        endcase
    endfunction

endpackage

// File: rtl/sap_microcode_rom.sv
// Combinational microcode: (opcode, T-state, latched flags) -> control word,
// plus the flag-write, halt-request and last-step markers for the sequencer.
module sap_microcode_rom
    import sap_pkg::*;
(
    input  logic [3:0]            opcode,
    input  logic [SAP_STEP_W-1:0] step,
    input  logic                  flag_c,
    input  logic                  flag_z,
    output ctrl_word_t            ctrl,
    output logic                  flag_we,
    output logic                  halt_req,
    output logic                  last_step
);

    always_comb begin
        ctrl     = '0;
        flag_we  = 1'b0;
        halt_req = 1'b0;
        case (step)
            T0: begin
                ctrl.pc_out   = 1'b1;
                ctrl.mar_load = 1'b1;
            end
            T1: begin
                ctrl.ram_out = 1'b1;
                ctrl.ir_load = 1'b1;
                ctrl.pc_inc  = 1'b1;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl.ir_out   = 1'b1;
                        ctrl.mar_load = 1'b1;
                    end
                    OP_LDI: begin
                        ctrl.ir_out = 1'b1;
                        ctrl.a_load = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl.ir_out  = 1'b1;
                        ctrl.pc_load = 1'b1;
                    end
                    // Conditional jumps only ever look at the latched flags
                    OP_JC: begin
                        ctrl.ir_out  = 1'b1;
                        ctrl.pc_load = flag_c;
                    end
                    OP_JZ: begin
                        ctrl.ir_out  = 1'b1;
                        ctrl.pc_load = flag_z;
                    end
                    OP_OUT: begin
                        ctrl.a_out    = 1'b1;
                        ctrl.out_load = 1'b1;
                    end
                    OP_HLT:  halt_req = 1'b1;
                    default: ;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        ctrl.ram_out = 1'b1;
                        ctrl.a_load  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl.ram_out = 1'b1;
                        ctrl.b_load  = 1'b1;
                    end
                    OP_STA: begin
                        ctrl.a_out    = 1'b1;
                        ctrl.ram_load = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ctrl.alu_out = 1'b1;
                    ctrl.a_load  = 1'b1;
                    ctrl.alu_sub = (opcode == OP_SUB);
                    flag_we      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign last_step = (step == instr_len(opcode) - 3'd1);

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP control unit: T-state counter, flag and halt registers, with the
// microcode ROM output gated by run enable, reset and halt.
module sap_control_sequencer
    import sap_pkg::*;
#(
    parameter int STEP_W = SAP_STEP_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [3:0] ir_opcode,
    input  logic       alu_cf,
    input  logic       alu_zf,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ram_load,
    output logic       ir_load,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       b_load,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       out_load,
    output logic       flag_c,
    output logic       flag_z,
    output logic       halted
);

    logic [STEP_W-1:0] step;
    logic              halt_q;
    ctrl_word_t        rom_ctrl;
    ctrl_word_t        ctrl;
    logic              rom_flag_we;
    logic              rom_halt_req;
    logic              rom_last;
    logic              run;

    sap_microcode_rom u_rom (
        .opcode    (ir_opcode),
        .step      (step),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .ctrl      (rom_ctrl),
        .flag_we   (rom_flag_we),
        .halt_req  (rom_halt_req),
        .last_step (rom_last)
    );

    // A step only executes when nothing is holding the machine
    assign run  = ena & ~halt_q & ~rst;
    assign ctrl = run ? rom_ctrl : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            step   <= STEP_W'(T0);
            halt_q <= 1'b0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (run) begin
            if (rom_halt_req) halt_q <= 1'b1;
            if (rom_flag_we) begin
                flag_c <= alu_cf;
                flag_z <= alu_zf;
            end
            step <= rom_last ? STEP_W'(T0) : step + STEP_W'(1);
        end
    end

    assign pc_out   = ctrl.pc_out;
    assign pc_inc   = ctrl.pc_inc;
    assign pc_load  = ctrl.pc_load;
    assign mar_load = ctrl.mar_load;
    assign ram_out  = ctrl.ram_out;
    assign ram_load = ctrl.ram_load;
    assign ir_load  = ctrl.ir_load;
    assign ir_out   = ctrl.ir_out;
    assign a_load   = ctrl.a_load;
    assign a_out    = ctrl.a_out;
    assign b_load   = ctrl.b_load;
    assign alu_out  = ctrl.alu_out;
    assign alu_sub  = ctrl.alu_sub;
    assign out_load = ctrl.out_load;
    assign halted   = halt_q;

endmodule
